fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Sequencer for the fetch stage. It computes the next PC and drives the PC register's write-hold input. It tracks the one-cycle synchronous instruction-memory read, stalls on issue-queue backpressure through a 1-entry hold buffer, and applies ROB flush and branch redirects that kill wrong-path fetches. It sits between the PC/instruction-memory block and the issue queue.

Parameters:
XLEN, 32, width of PC and instruction
INSTR_BYTES, 4, sequential PC increment
HALT_INSTR, 32'h00000073, instruction encoding that halts fetch once delivered

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low; reset==0 at posedge clk resets the block
pc  in  XLEN  current PC register value, which is also the imem read address this cycle
instruction  in  XLEN  imem read data for the address presented in the previous cycle
pc_update  out  XLEN  next PC value, driven to the PC register
pc_hold  out  1  1 = PC register must not load (connects to the PC block's queue_full)
iq_ready  in  1  issue queue can accept a fetch packet this cycle
fetch_valid  out  1  fetch packet valid; transfer occurs when fetch_valid && iq_ready
fetch_pc  out  XLEN  PC of the delivered instruction
fetch_instr  out  XLEN  delivered instruction
flush_valid  in  1  ROB flush / exception redirect
flush_pc  in  XLEN  flush target
br_valid  in  1  branch-unit mispredict redirect
br_target  in  XLEN  branch target
halted  out  1  fetch halted

Behaviour:
- Reset (reset==0): state=RUN, req_valid_q=0, hold buffer empty, halted=0, fetch_valid=0, fetch_pc=fetch_instr=0, pc_hold=0. The PC register resets to 0 in the same cycle.
- Live-fetch tracking:
  - req_valid_q <= !pc_hold && !redirect; req_pc_q <= pc.
  - resp_live = req_valid_q && state!=HALT.
  - The PC advances only in a cycle whose fetch is recorded live. A held PC simply re-reads the same address next cycle.
- Latency: an address presented in cycle N gives a fetch packet in cycle N+1 (fetch_pc=req_pc_q, fetch_instr=instruction) when no hold or redirect intervenes.
- Redirect:
  - redirect = flush_valid || br_valid.
  - Priority: flush_valid over br_valid.
  - pc_update = flush_pc, else br_target, else pc+INSTR_BYTES. Bits [1:0] of the target are forced to 0.
  - In the redirect cycle: pc_hold=0 (overrides every hold cause), fetch_valid=0, hold buffer cleared, req_valid_q<=0. The target's fetch appears at redirect cycle+2.
- Output mux: if the hold buffer is full, present its contents; else present the live response. fetch_valid = (hold_full || resp_live) && !redirect && state!=HALT.
- Backpressure:
  - If resp_live && !iq_ready && !redirect, capture {req_pc_q, instruction} into the hold buffer.
  - pc_hold = (state==HALT && !flush_valid) || (!iq_ready && (hold_full || resp_live)) && !redirect.
  - hold_full and resp_live are never both 1; the bench asserts this.
- FSM states:
  - RUN: hold buffer empty. Enter STALL on a capture.
  - STALL: hold buffer full. Return to RUN when the hold entry transfers or on any redirect.
  - HALT:
    - Entered from RUN/STALL when a transfer has fetch_instr==HALT_INSTR.
    - On entry: halted=1, pc_hold=1, responses discarded.
    - Exits to RUN only on flush_valid, which loads flush_pc. br_valid is ignored in HALT.
- Simultaneous events:
  - Redirect in the same cycle as a would-be transfer: the transfer is suppressed.
  - HALT_INSTR transfer together with a redirect: no transfer, so no halt.
  - Reset mid-stall or mid-halt: all state is cleared; outstanding data is dropped.
- Wrap-around: pc+INSTR_BYTES wraps modulo 2^XLEN (32'hFFFFFFFC -> 0), no flag.

Decomposition:
- structs.svh: XLEN, INSTR_BYTES, HALT_INSTR, typedef fetch_state_t {RUN, STALL, HALT}, typedef fetch_pkt_t {pc, instr}.
- Sub-module fetch_hold_buf: 1-entry skid register with load/drain/clear, full flag, and a fetch_pkt_t data port.

Test Plan:
- Reset release, iq_ready=1 for 5 cycles: fetch_valid from cycle 2 with fetch_pc 0,4,8,12; pc_hold=0 throughout.
- iq_ready=0 while the packet for pc=8 is live: hold buffer captures pc=8, pc_hold=1, pc stays 12. iq_ready=1 two cycles later: pc=8 transfers, then 12, 16 with no duplicate and no gap.
- flush_valid(pc=0x100) and br_valid(0x200) in the same cycle: fetch_valid=0 that cycle, the next delivered fetch_pc=0x100, the wrong-path packet is never delivered.
- br_valid(0x40) while in STALL with iq_ready=0: hold buffer cleared, fetch_pc 0x40 delivered 2 cycles later.
- Deliver 32'h00000073 at pc=0x10: halted=1 next cycle, fetch_valid=0, pc frozen; br_valid ignored; flush_valid(0x80) resumes with fetch_pc=0x80.
- reset=0 asserted in STALL with pc=0x24: all outputs return to reset values; after release the first fetch_pc=0.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared widths, state encoding and packet type for the fetch sequencer.
package fetch_ctrl_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;
    localparam logic [XLEN-1:0] HALT_INSTR = 32'h0000_0073;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_pkt_t;

    // Redirect targets are word aligned; the low two bits are discarded.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return addr & {{(XLEN-2){1'b1}}, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-to-issue-queue handshake: packet valid/data forward, ready backward.
interface fetch_ctrl_if;
    import fetch_ctrl_pkg::*;

    logic            fetch_valid;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] fetch_instr;
    logic            iq_ready;

    modport master (
        output fetch_valid,
        output fetch_pc,
        output fetch_instr,
        input  iq_ready
    );

    modport slave (
        input  fetch_valid,
        input  fetch_pc,
        input  fetch_instr,
        output iq_ready
    );

endinterface

// File: rtl/fetch_hold_buf.sv
// One-entry skid register holding a fetch packet the issue queue refused.
module fetch_hold_buf
    import fetch_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       drain,
    input  logic       clear,
    input  fetch_pkt_t load_pkt,
    output fetch_pkt_t hold_pkt,
    output logic       full
);

    logic       full_reg;
    fetch_pkt_t pkt_reg;

    // clear wins over load so a redirect can never leave wrong-path data behind
    always_ff @(posedge clk) begin
        if (!reset) begin
            full_reg <= 1'b0;
            pkt_reg  <= '0;
        end else if (clear) begin
            full_reg <= 1'b0;
        end else if (load) begin
            full_reg <= 1'b1;
            pkt_reg  <= load_pkt;
        end else if (drain) begin
            full_reg <= 1'b0;
        end
    end

    assign full     = full_reg;
    assign hold_pkt = pkt_reg;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: next-PC selection, imem response tracking,
// issue-queue backpressure via a skid entry, redirects and halt.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] pc_update,
    output logic            pc_hold,
    fetch_ctrl_if.master    iq,
    input  logic            flush_valid,
    input  logic [XLEN-1:0] flush_pc,
    input  logic            br_valid,
    input  logic [XLEN-1:0] br_target,
    output logic            halted
);

    fetch_state_t    state_reg;
    fetch_state_t    state_next;
    logic            req_valid_reg;
    logic [XLEN-1:0] req_pc_reg;

    logic            redirect;
    logic            resp_live;
    logic            hold_full;
    logic            capture;
    logic            drain;
    logic            transfer;
    fetch_pkt_t      hold_pkt;
    fetch_pkt_t      live_pkt;
    fetch_pkt_t      out_pkt;

    fetch_hold_buf u_hold_buf (
        .clk      (clk),
        .reset    (reset),
        .load     (capture),
        .drain    (drain),
        .clear    (redirect),
        .load_pkt (live_pkt),
        .hold_pkt (hold_pkt),
        .full     (hold_full)
    );

    always_comb begin
        // A halted front end only listens to the ROB; branch redirects are stale.
        redirect  = flush_valid || (br_valid && (state_reg != HALT));
        resp_live = req_valid_reg && (state_reg != HALT);
        live_pkt  = '{pc: req_pc_reg, instr: instruction};

        if (hold_full)
            out_pkt = hold_pkt;
        else if (resp_live)
            out_pkt = live_pkt;
        else
            out_pkt = '0;

        iq.fetch_valid = (hold_full || resp_live) && !redirect && (state_reg != HALT);
        iq.fetch_pc    = out_pkt.pc;
        iq.fetch_instr = out_pkt.instr;

        transfer = iq.fetch_valid && iq.iq_ready;
        capture  = resp_live && !iq.iq_ready && !redirect;
        drain    = hold_full && iq.iq_ready && !redirect;

        pc_hold = ((state_reg == HALT) && !flush_valid)
                || (!iq.iq_ready && (hold_full || resp_live) && !redirect);

        if (flush_valid)
            pc_update = align_pc(flush_pc);
        else if (br_valid && (state_reg != HALT))
            pc_update = align_pc(br_target);
        else
            pc_update = pc + XLEN'(INSTR_BYTES);

        halted = (state_reg == HALT);
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN: begin
                if (redirect)
                    state_next = RUN;
                else if (transfer && (iq.fetch_instr == HALT_INSTR))
                    state_next = HALT;
                else if (capture)
                    state_next = STALL;
            end
            STALL: begin
                if (redirect)
                    state_next = RUN;
                else if (transfer)
                    state_next = (iq.fetch_instr == HALT_INSTR) ? HALT : RUN;
            end
            HALT: begin
                if (flush_valid)
                    state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    // The address on pc this cycle is only tracked if the PC is allowed to move past it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= RUN;
            req_valid_reg <= 1'b0;
            req_pc_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            req_valid_reg <= !pc_hold && !redirect;
            req_pc_reg    <= pc;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed scoreboard bench for fetch_ctrl with a behavioural PC register and imem.
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic [31:0] pc_update;
    logic        pc_hold;
    logic        flush_valid = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        br_valid = 1'b0;
    logic [31:0] br_target = '0;
    logic        halted;
    logic [31:0] halt_addr = 32'hFFFF_0000;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    fetch_ctrl_if iq_if();

    fetch_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .instruction (instruction),
        .pc_update   (pc_update),
        .pc_hold     (pc_hold),
        .iq          (iq_if),
        .flush_valid (flush_valid),
        .flush_pc    (flush_pc),
        .br_valid    (br_valid),
        .br_target   (br_target),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a, input logic [31:0] ha);
        return (a == ha) ? 32'h0000_0073 : (a ^ 32'hC0DE_0000);
    endfunction

    // PC register and synchronous imem surrounding the sequencer
    always @(posedge clk) begin
        if (!reset)
            pc <= 32'h0;
        else if (!pc_hold)
            pc <= pc_update;
        instruction <= imem(pc, halt_addr);
    end

    task automatic cyc(input logic r, input logic rdy, input logic fv, input logic [31:0] fp,
                       input logic bv, input logic [31:0] bt);
        @(posedge clk);
        #1;
        reset           = r;
        iq_if.iq_ready  = rdy;
        flush_valid     = fv;
        flush_pc        = fp;
        br_valid        = bv;
        br_target       = bt;
        @(negedge clk);
    endtask

    task automatic run(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cyc(1'b1, rdy, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    task automatic push(input logic [31:0] p, input logic [31:0] ins);
        exp_t e;
        e.pc    = p;
        e.instr = ins;
        exp_q.push_back(e);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " fetch_valid"}, {31'b0, iq_if.fetch_valid}, 32'h0);
        chk({tag, " fetch_pc"},    iq_if.fetch_pc,             32'h0);
        chk({tag, " fetch_instr"}, iq_if.fetch_instr,          32'h0);
        chk({tag, " pc_hold"},     {31'b0, pc_hold},           32'h0);
        chk({tag, " halted"},      {31'b0, halted},            32'h0);
    endtask

    initial begin
        iq_if.iq_ready = 1'b0;
        fork
            begin : monitor
                exp_t e;
                forever begin
                    @(negedge clk);
                    checks++;
                    if (dut.hold_full && dut.resp_live) begin
                        errors++;
                        $display("FAIL invariant: hold_full=1 resp_live=1 want not both");
                    end
                    if (reset && iq_if.fetch_valid && iq_if.iq_ready) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL xfer unexpected: pc=%h instr=%h want none",
                                     iq_if.fetch_pc, iq_if.fetch_instr);
                        end else begin
                            e = exp_q.pop_front();
                            if (iq_if.fetch_pc !== e.pc || iq_if.fetch_instr !== e.instr) begin
                                errors++;
                                $display("FAIL xfer: pc=%h instr=%h want pc=%h instr=%h",
                                         iq_if.fetch_pc, iq_if.fetch_instr, e.pc, e.instr);
                            end else begin
                                $display("xfer pc=%h instr=%h ok", e.pc, e.instr);
                            end
                        end
                    end
                end
            end
            begin : stimulus
                // reset state
                cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
                cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
                chk_reset_vals("reset");

                // sequential fetch, then a two-cycle stall on pc=8
                push(32'h0, 32'hC0DE_0000);
                push(32'h4, 32'hC0DE_0004);
                push(32'h8, 32'hC0DE_0008);
                push(32'hC, 32'hC0DE_000C);
                push(32'h10, 32'hC0DE_0010);
                push(32'h100, 32'hC0DE_0100);
                cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
                chk("c0 fetch_valid", {31'b0, iq_if.fetch_valid}, 32'h0);
                chk("c0 pc_hold", {31'b0, pc_hold}, 32'h0);
                run(1, 1'b1);
                chk("c1 pc_hold", {31'b0, pc_hold}, 32'h0);
                run(1, 1'b1);
                chk("c2 pc_hold", {31'b0, pc_hold}, 32'h0);
                run(1, 1'b0);
                chk("capture pc_hold", {31'b0, pc_hold}, 32'h1);
                chk("capture pc", pc, 32'hC);
                run(1, 1'b0);
                chk("stall pc_hold", {31'b0, pc_hold}, 32'h1);
                chk("stall pc", pc, 32'hC);
                chk("stall fetch_pc", iq_if.fetch_pc, 32'h8);
                run(1, 1'b1);
                chk("drain pc_hold", {31'b0, pc_hold}, 32'h0);
                run(2, 1'b1);

                // flush and branch together: flush wins, live packet dropped
                cyc(1'b1, 1'b1, 1'b1, 32'h100, 1'b1, 32'h200);
                chk("flush fetch_valid", {31'b0, iq_if.fetch_valid}, 32'h0);
                chk("flush pc_update", pc_update, 32'h100);
                run(1, 1'b1);
                chk("flush+1 fetch_valid", {31'b0, iq_if.fetch_valid}, 32'h0);
                chk("flush+1 pc", pc, 32'h100);

                // branch (unaligned target) while stalled
                push(32'h40, 32'hC0DE_0040);
                run(1, 1'b1);
                run(1, 1'b0);
                cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h43);
                chk("br stall fetch_valid", {31'b0, iq_if.fetch_valid}, 32'h0);
                chk("br stall pc_hold", {31'b0, pc_hold}, 32'h0);
                chk("br pc_update", pc_update, 32'h40);
                run(1, 1'b1);
                chk("br+1 fetch_valid", {31'b0, iq_if.fetch_valid}, 32'h0);
                run(1, 1'b1);

                // halt instruction at 0x10
                halt_addr = 32'h10;
                push(32'h8, 32'hC0DE_0008);
                push(32'hC, 32'hC0DE_000C);
                push(32'h10, 32'h0000_0073);
                push(32'h80, 32'hC0DE_0080);
                cyc(1'b1, 1'b1, 1'b1, 32'h8, 1'b0, 32'h0);
                chk("flush8 fetch_valid", {31'b0, iq_if.fetch_valid}, 32'h0);
                run(4, 1'b1);
                run(1, 1'b1);
                chk("halt halted", {31'b0, halted}, 32'h1);
                chk("halt fetch_valid", {31'b0, iq_if.fetch_valid}, 32'h0);
                chk("halt pc_hold", {31'b0, pc_hold}, 32'h1);
                chk("halt pc", pc, 32'h18);
                cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h200);
                chk("halt br pc_hold", {31'b0, pc_hold}, 32'h1);
                chk("halt br fetch_valid", {31'b0, iq_if.fetch_valid}, 32'h0);
                cyc(1'b1, 1'b1, 1'b1, 32'h80, 1'b0, 32'h0);
                chk("halt br pc", pc, 32'h18);
                chk("halt flush pc_hold", {31'b0, pc_hold}, 32'h0);
                chk("halt flush halted", {31'b0, halted}, 32'h1);
                halt_addr = 32'hFFFF_0000;
                run(1, 1'b1);
                chk("resume halted", {31'b0, halted}, 32'h0);
                chk("resume pc", pc, 32'h80);
                run(1, 1'b1);

                // reset while stalled at pc=0x24
                push(32'h1C, 32'hC0DE_001C);
                push(32'h0, 32'hC0DE_0000);
                push(32'h4, 32'hC0DE_0004);
                push(32'hFFFF_FFFC, 32'h3F21_FFFC);
                push(32'h0, 32'hC0DE_0000);
                cyc(1'b1, 1'b1, 1'b1, 32'h1C, 1'b0, 32'h0);
                run(2, 1'b1);
                run(1, 1'b0);
                chk("stall2 pc_hold", {31'b0, pc_hold}, 32'h1);
                chk("stall2 pc", pc, 32'h24);
                cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
                chk("stall2 state", {30'b0, dut.state_reg}, {30'b0, STALL});
                cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
                chk_reset_vals("midreset");
                chk("midreset pc", pc, 32'h0);
                run(3, 1'b1);

                // wrap-around of the sequential increment
                cyc(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
                run(1, 1'b1);
                chk("wrap pc", pc, 32'hFFFF_FFFC);
                chk("wrap pc_update", pc_update, 32'h0);
                run(2, 1'b1);
                run(3, 1'b0);
                chk("scoreboard drained", exp_q.size(), 32'h0);
            end
        join_any
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
